da_sched: RTL
=============

Name: da_sched

Overview:
- Sequencing controller for the distributed-arithmetic FIR datapath (`da`); sits between the sample/coefficient streams and `da`.
- Holds a 64-tap, 8-bit sample delay line and forms the eight 8-bit bit-plane LUT addresses for each bit plane.
- Runs 8 MSB-first `da` passes per sample, returns the accumulated result on a valid/ready stream, and serialises coefficient-RAM loads with filtering.

Parameters:
- TAPS, 64, delay-line depth; fixed at 8 banks x 8 taps.
- SW, 8, sample width = number of bit planes.
- CLOAD_CYC, 2, cycles da_cload/da_cin/da_caddr are held per coefficient word.
- ACC_LAT, 2, cycles after da_done before da_acc holds the updated value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when both high
- s_data  in  8  unsigned (offset-binary) sample
- c_valid  in  1  coefficient word valid
- c_ready  out  1  coefficient word accepted when both high
- c_data  in  20  coefficient LUT word
- c_addr  in  11  coefficient LUT address
- y_valid  out  1  result valid
- y_ready  in  1  result accepted
- y_data  out  39  filter output
- da_addr  out  64  {A7..A0}; A_k = da_addr[8k+7:8k]
- da_start  out  1  one-cycle start pulse to da
- da_done  in  1  pass-complete from da
- da_acc_clr  out  1  drives da reset (clears ACC)
- da_acc  in  39  da ACC_OUT
- da_cload  out  1  da CLOAD
- da_cin  out  20  da CIN
- da_caddr  out  11  da CADDR

Behaviour:
- Reset, sync: state IDLE, all taps 0, bit index 7; every output 0 except s_ready=1 and c_ready=1 in IDLE.
- Reset mid-operation: abandons the pass; da_start, da_cload and y_valid drop the next cycle; no partial result is emitted.
- States: IDLE, CLOAD, SHIFT, CLR, ISSUE, WAIT, SETTLE, OUT.
- IDLE:
  - s_ready = c_ready = 1 only here.
  - c_valid takes priority: if c_valid, only the coefficient is accepted that cycle.
  - Coefficient accepted -> CLOAD. Sample accepted -> SHIFT.
- CLOAD: da_cload=1; da_cin/da_caddr hold the latched word for CLOAD_CYC cycles -> IDLE.
- SHIFT: one cycle; tap[i] <= tap[i-1] for i=63..1, tap[0] <= sample, b <= 7 -> CLR.
- CLR: da_acc_clr=1 for one cycle -> ISSUE.
- Addressing: da_addr bit (8k+t) = tap[8k+t][b]. da_addr is registered, stable from ISSUE through end of WAIT.
- ISSUE: da_start=1 for one cycle -> WAIT.
- WAIT: hold until da_done=1 -> SETTLE.
- SETTLE: wait ACC_LAT cycles.
  - b>0: b <= b-1 -> ISSUE.
  - b=0: latch y_data <= da_acc -> OUT.
- Bit order: MSB first. da computes ACC = 2*ACC + plane, so 8 passes give Σ coeff-LUT(plane_b)*2^b with no sign correction. Samples are unsigned by decision.
- OUT: y_valid=1, y_data stable until y_ready=1; then y_valid=0 next cycle -> IDLE.
- Back-to-back: one sample per (3 + 8*(2+da_lat+ACC_LAT) + 1) cycles minimum. There is no sample/compute overlap.
- da_done seen outside WAIT is ignored.
- Width rules:
  - y_data is the full 39 bits with no truncation.
  - c_addr is passed through unmodified; LUT layout is owned by the software/bench.

Decomposition:
- Shared package `da_pkg`:
  - state encoding constants
  - SW, TAPS, NBANK=8
  - widths ACC_W=39, COEF_W=20, CADDR_W=11
- One natural sub-module, `da_tapline`: 64x8 shift register with synchronous clear, a shift enable and a bit-plane select b; outputs the 64-bit da_addr (registered).
- Top: FSM, counters, handshakes.

Test Plan:
- Reset asserted 3 cycles -> y_valid=0, da_start=0, da_cload=0, da_addr=0, s_ready=1, c_ready=1.
- Load words (addr 0x000, data 0x00001), (0x001, 0xFFFFF) -> da_cload high 2 cycles each with matching da_caddr/da_cin; s_ready=0 throughout.
- After reset, sample 0x81 -> one da_acc_clr pulse, then 8 da_start pulses; da_addr=0x...01 for b=7 and b=0, 0 for b=6..1. With a da stub returning LUT[1]=5, y_data=5*129=645.
- s_valid and c_valid high together in IDLE -> c_ready handshake only; sample accepted after the CLOAD completes.
- y_ready low for 5 cycles in OUT -> y_valid held, y_data constant, s_ready=0; release -> one transfer, return to IDLE.
- Reset pulsed during WAIT of the 3rd plane -> next cycle IDLE, da_start=0, no y_valid. A new 0x80 sample then yields only the b=7 address nonzero.

Source files
------------

// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic FIR sequencer: sizes,
// widths, the sequencer state encoding and the bit-plane extraction helper.
package da_pkg;

  localparam int TAPS      = 64;
  localparam int SW        = 8;
  localparam int NBANK     = 8;
  localparam int ACC_W     = 39;
  localparam int COEF_W    = 20;
  localparam int CADDR_W   = 11;
  localparam int CLOAD_CYC = 2;
  localparam int ACC_LAT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLOAD  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_CLR    = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_SETTLE = 3'd6,
    ST_OUT    = 3'd7
  } state_t;

  // Bit b of every tap, tap i landing on address bit i, so bank k's
  // address is bits [8k+7:8k].
  function automatic logic [TAPS-1:0] plane_sel(input logic [TAPS-1:0][SW-1:0] taps,
                                                input logic [2:0]              b);
    logic [TAPS-1:0] p;
    p = '0;
    for (int i = 0; i < TAPS; i++) begin
      p[i] = taps[i][b];
    end
    return p;
  endfunction

endpackage

// File: rtl/da_tapline.sv
// 64 x 8-bit sample delay line with a registered bit-plane address output.
// The address register loads only on request, so it stays stable for the
// whole da pass regardless of what the plane select does meanwhile.
module da_tapline
  import da_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            shift_en,
  input  logic [SW-1:0]   din,
  input  logic            load,
  input  logic [2:0]      sel,
  output logic [TAPS-1:0] addr
);

  logic [TAPS-1:0][SW-1:0] taps_r;
  logic [TAPS-1:0]         addr_r;

  // Delay line: newest sample enters tap 0, everything else moves up one.
  always_ff @(posedge clk) begin
    if (clr) begin
      taps_r <= '0;
    end else if (shift_en) begin
      taps_r <= {taps_r[TAPS-2:0], din};
    end else begin
      taps_r <= taps_r;
    end
  end

  // Address register: captures the selected bit plane when asked to.
  always_ff @(posedge clk) begin
    if (clr) begin
      addr_r <= '0;
    end else if (load) begin
      addr_r <= plane_sel(taps_r, sel);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/da_sched.sv
// Sequencer between the sample/coefficient streams and the da datapath.
// Per sample: shift the delay line, clear ACC, run eight MSB-first passes,
// then present the 39-bit accumulation on the y stream. Coefficient loads
// are serialised with filtering and only start from IDLE.
module da_sched
  import da_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SW-1:0]      s_data,
  input  logic               c_valid,
  output logic               c_ready,
  input  logic [COEF_W-1:0]  c_data,
  input  logic [CADDR_W-1:0] c_addr,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [ACC_W-1:0]   y_data,
  output logic [TAPS-1:0]    da_addr,
  output logic               da_start,
  input  logic               da_done,
  output logic               da_acc_clr,
  input  logic [ACC_W-1:0]   da_acc,
  output logic               da_cload,
  output logic [COEF_W-1:0]  da_cin,
  output logic [CADDR_W-1:0] da_caddr
);

  state_t               state_r;
  logic [1:0]           cnt_r;
  logic [2:0]           b_r;
  logic [SW-1:0]        sample_r;
  logic                 ready_r;
  logic                 da_start_r;
  logic                 da_acc_clr_r;
  logic                 da_cload_r;
  logic [COEF_W-1:0]    da_cin_r;
  logic [CADDR_W-1:0]   da_caddr_r;
  logic                 y_valid_r;
  logic [ACC_W-1:0]     y_data_r;

  logic                 shift_en_s;
  logic                 addr_load_s;
  logic [2:0]           sel_s;
  logic                 settle_done_s;

  // Tapline control: shift in SHIFT, load the MSB plane at the end of CLR,
  // and load the next lower plane on the SETTLE cycle that re-issues.
  always_comb begin
    shift_en_s    = 1'b0;
    addr_load_s   = 1'b0;
    sel_s         = 3'd7;
    settle_done_s = (cnt_r == 2'(ACC_LAT - 1));
    if (state_r == ST_SHIFT) begin
      shift_en_s = 1'b1;
    end else begin
      shift_en_s = 1'b0;
    end
    if (state_r == ST_CLR) begin
      addr_load_s = 1'b1;
      sel_s       = 3'd7;
    end else if ((state_r == ST_SETTLE) && settle_done_s && (b_r != 3'd0)) begin
      addr_load_s = 1'b1;
      sel_s       = b_r - 3'd1;
    end else begin
      addr_load_s = 1'b0;
      sel_s       = 3'd7;
    end
  end

  da_tapline u_tapline (
    .clk      (clk),
    .clr      (reset),
    .shift_en (shift_en_s),
    .din      (sample_r),
    .load     (addr_load_s),
    .sel      (sel_s),
    .addr     (da_addr)
  );

  // Sequencer FSM with all da/stream controls registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 2'd0;
      b_r          <= 3'd7;
      sample_r     <= {SW{1'b0}};
      ready_r      <= 1'b1;
      da_start_r   <= 1'b0;
      da_acc_clr_r <= 1'b0;
      da_cload_r   <= 1'b0;
      da_cin_r     <= {COEF_W{1'b0}};
      da_caddr_r   <= {CADDR_W{1'b0}};
      y_valid_r    <= 1'b0;
      y_data_r     <= {ACC_W{1'b0}};
    end else begin
      da_start_r   <= 1'b0;
      da_acc_clr_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (c_valid) begin
            da_cin_r   <= c_data;
            da_caddr_r <= c_addr;
            da_cload_r <= 1'b1;
            cnt_r      <= 2'd0;
            ready_r    <= 1'b0;
            state_r    <= ST_CLOAD;
          end else if (s_valid) begin
            sample_r <= s_data;
            ready_r  <= 1'b0;
            state_r  <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLOAD: begin
          if (cnt_r == 2'(CLOAD_CYC - 1)) begin
            da_cload_r <= 1'b0;
            ready_r    <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        ST_SHIFT: begin
          b_r          <= 3'd7;
          da_acc_clr_r <= 1'b1;
          state_r      <= ST_CLR;
        end
        ST_CLR: begin
          da_start_r <= 1'b1;
          state_r    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (da_done) begin
            cnt_r   <= 2'd0;
            state_r <= ST_SETTLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_SETTLE: begin
          if (settle_done_s) begin
            if (b_r != 3'd0) begin
              b_r        <= b_r - 3'd1;
              da_start_r <= 1'b1;
              state_r    <= ST_ISSUE;
            end else begin
              y_data_r  <= da_acc;
              y_valid_r <= 1'b1;
              state_r   <= ST_OUT;
            end
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        ST_OUT: begin
          if (y_ready) begin
            y_valid_r <= 1'b0;
            ready_r   <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          da_cload_r <= 1'b0;
          y_valid_r  <= 1'b0;
          ready_r    <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // A pending coefficient wins in IDLE, so the sample side must not look
  // ready in that cycle or the handshake would claim a sample we dropped.
  assign s_ready    = ready_r & ~c_valid;
  assign c_ready    = ready_r;
  assign y_valid    = y_valid_r;
  assign y_data     = y_data_r;
  assign da_start   = da_start_r;
  assign da_acc_clr = da_acc_clr_r;
  assign da_cload   = da_cload_r;
  assign da_cin     = da_cin_r;
  assign da_caddr   = da_caddr_r;

endmodule
